stall_control: RTL and testbench

STALL_CONTROL -- requirements
Module: stall_control

---
 rtl/stall_control.sv | 122 ++++++++++++
 tb/tb_stall_control.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stall_control.sv
// ============================================================================
// Module  : stall_control
// Purpose : Pipeline hazard FSM producing registered stall/flush/bubble enables.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stall_control (
  input  logic        clock,
  input  logic        reset,
  input  logic        fw_sc_stall,
  input  logic        ex_sc_branch,
  input  logic        mem_sc_busy,
  output logic        sc_pc_enable,
  output logic        sc_if_id_hold,
  output logic        sc_if_id_flush,
  output logic        sc_id_ex_bubble,
  output logic        sc_id_ex_hold,
  output logic        sc_ex_mem_hold,
  output logic        sc_mem_wb_bubble,
  output logic        sc_timeout,
  output logic [15:0] sc_stall_count,
  output logic [1:0]  sc_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOADUSE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_flush_cnt;
  logic [1:0]  w_flush_cnt_next;
  logic        r_pend;
  logic        w_pend_next;
  logic [7:0]  r_wait_cnt;

  always_comb begin
    w_next           = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_pend_next      = r_pend;
    case (r_state)
      ST_MEMWAIT: begin
        if (mem_sc_busy) begin
          w_pend_next = r_pend | ex_sc_branch;
        end else if (r_pend || ex_sc_branch) begin
          w_next           = ST_FLUSH;
          w_flush_cnt_next = 2'd2;
          w_pend_next      = 1'b0;
        end else begin
          w_next = ST_RUN;
        end
      end
      default: begin
        if (mem_sc_busy) begin
          // An interrupted flush is replayed in full once memory releases.
          w_next           = ST_MEMWAIT;
          w_pend_next      = ex_sc_branch | (r_state == ST_FLUSH);
          w_flush_cnt_next = 2'd0;
        end else if (ex_sc_branch) begin
          w_next           = ST_FLUSH;
          w_flush_cnt_next = 2'd2;
        end else if (r_state == ST_FLUSH && r_flush_cnt > 2'd1) begin
          w_flush_cnt_next = r_flush_cnt - 2'd1;
        end else if (r_state == ST_RUN && fw_sc_stall) begin
          w_next = ST_LOADUSE;
        end else begin
          w_next           = ST_RUN;
          w_flush_cnt_next = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= ST_RUN;
      r_flush_cnt      <= 2'd0;
      r_pend           <= 1'b0;
      r_wait_cnt       <= 8'd0;
      sc_timeout       <= 1'b0;
      sc_stall_count   <= 16'd0;
      sc_pc_enable     <= 1'b1;
      sc_if_id_hold    <= 1'b0;
      sc_if_id_flush   <= 1'b0;
      sc_id_ex_bubble  <= 1'b0;
      sc_id_ex_hold    <= 1'b0;
      sc_ex_mem_hold   <= 1'b0;
      sc_mem_wb_bubble <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_pend      <= w_pend_next;

      if (r_state != ST_RUN && sc_stall_count != 16'hFFFF)
        sc_stall_count <= sc_stall_count + 16'd1;

      if (r_state == ST_MEMWAIT) begin
        if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
        if (r_wait_cnt == 8'd254) sc_timeout <= 1'b1;
      end else if (w_next == ST_MEMWAIT) begin
        r_wait_cnt <= 8'd0;
      end

      sc_pc_enable     <= (w_next == ST_RUN) || (w_next == ST_FLUSH);
      sc_if_id_hold    <= (w_next == ST_LOADUSE) || (w_next == ST_MEMWAIT);
      sc_if_id_flush   <= (w_next == ST_FLUSH);
      sc_id_ex_bubble  <= (w_next == ST_LOADUSE) || (w_next == ST_FLUSH);
      sc_id_ex_hold    <= (w_next == ST_MEMWAIT);
      sc_ex_mem_hold   <= (w_next == ST_MEMWAIT);
      sc_mem_wb_bubble <= (w_next == ST_MEMWAIT);
    end
  end

  assign sc_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_stall_control.sv
// ============================================================================
// Module  : tb_stall_control
// Purpose : Directed and random stimulus against a behavioural hazard model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stall_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fw_sc_stall = 1'b0;
  logic        ex_sc_branch = 1'b0;
  logic        mem_sc_busy = 1'b0;
  logic        sc_pc_enable, sc_if_id_hold, sc_if_id_flush, sc_id_ex_bubble;
  logic        sc_id_ex_hold, sc_ex_mem_hold, sc_mem_wb_bubble, sc_timeout;
  logic [15:0] sc_stall_count;
  logic [1:0]  sc_state;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  stall_control dut (
    .clock(clock), .reset(reset),
    .fw_sc_stall(fw_sc_stall), .ex_sc_branch(ex_sc_branch), .mem_sc_busy(mem_sc_busy),
    .sc_pc_enable(sc_pc_enable), .sc_if_id_hold(sc_if_id_hold),
    .sc_if_id_flush(sc_if_id_flush), .sc_id_ex_bubble(sc_id_ex_bubble),
    .sc_id_ex_hold(sc_id_ex_hold), .sc_ex_mem_hold(sc_ex_mem_hold),
    .sc_mem_wb_bubble(sc_mem_wb_bubble), .sc_timeout(sc_timeout),
    .sc_stall_count(sc_stall_count), .sc_state(sc_state)
  );

  always #5 clock = ~clock;

  // Reference model: mode 0 run, 1 load-use, 2 flush, 3 memory wait.
  int m_mode = 0;
  int m_flush_left = 0;
  bit m_pending = 1'b0;
  int m_wait = 0;
  bit m_tmo = 1'b0;
  int m_stalls = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_flush_left = 0; m_pending = 0; m_wait = 0; m_tmo = 0; m_stalls = 0;
    end else begin
      if (m_mode != 0 && m_stalls < 65535) m_stalls++;
      if (m_mode == 3) begin
        if (m_wait < 255) m_wait++;
        if (m_wait == 255) m_tmo = 1;
      end
      if (m_mode == 3) begin
        if (mem_sc_busy) m_pending = m_pending | ex_sc_branch;
        else if (m_pending || ex_sc_branch) begin
          m_mode = 2; m_flush_left = 2; m_pending = 0;
        end else m_mode = 0;
      end else if (mem_sc_busy) begin
        m_pending = ex_sc_branch || (m_mode == 2);
        m_mode = 3; m_wait = 0;
      end else if (ex_sc_branch) begin
        m_mode = 2; m_flush_left = 2;
      end else if (m_mode == 2 && m_flush_left > 1) begin
        m_flush_left--;
      end else if (m_mode == 0 && fw_sc_stall) begin
        m_mode = 1;
      end else begin
        m_mode = 0;
      end
    end
  end

  function automatic logic [6:0] expect_ctl(input int mode);
    // {pc_enable, if_id_hold, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold, mem_wb_bubble}
    case (mode)
      0:       return 7'b1000000;
      1:       return 7'b0101000;
      2:       return 7'b1011000;
      default: return 7'b0100111;
    endcase
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      logic [26:0] dut_v, mdl_v;
      dut_v = {sc_pc_enable, sc_if_id_hold, sc_if_id_flush, sc_id_ex_bubble, sc_id_ex_hold,
               sc_ex_mem_hold, sc_mem_wb_bubble, sc_timeout, sc_stall_count, sc_state};
      mdl_v = {expect_ctl(m_mode), m_tmo, m_stalls[15:0], m_mode[1:0]};
      n_cmp++;
      if (dut_v !== mdl_v) begin
        n_err++;
        $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, dut_v, mdl_v);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit busy, input bit br, input bit fw);
    mem_sc_busy = busy; ex_sc_branch = br; fw_sc_stall = fw;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_sc_busy = 0; ex_sc_branch = 0; fw_sc_stall = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    chk_en = 1'b1;
    reset = 1'b0;
    check("reset_state", sc_state, 0);
    check("reset_pc_enable", sc_pc_enable, 1);
    check("reset_count", sc_stall_count, 0);

    // Single load-use
    do_reset();
    cyc(0, 0, 1);
    check("lu_state", sc_state, 1);
    check("lu_ctl", {sc_pc_enable, sc_if_id_hold, sc_id_ex_bubble}, 3'b011);
    cyc(0, 0, 0);
    check("lu_back_run", sc_state, 0);
    check("lu_count", sc_stall_count, 1);

    // Held stall alternates
    do_reset();
    cyc(0, 0, 1); check("held_1", sc_state, 1);
    cyc(0, 0, 1); check("held_2", sc_state, 0);
    cyc(0, 0, 1); check("held_3", sc_state, 1);
    cyc(0, 0, 0); check("held_count", sc_stall_count, 2);

    // Branch flush and reload in second flush cycle
    do_reset();
    cyc(0, 1, 0); check("br_f1", sc_state, 2);
    check("br_ctl", {sc_pc_enable, sc_if_id_flush, sc_id_ex_bubble}, 3'b111);
    cyc(0, 0, 0); check("br_f2", sc_state, 2);
    cyc(0, 1, 0); check("br_reload1", sc_state, 2);
    cyc(0, 0, 0); check("br_reload2", sc_state, 2);
    cyc(0, 0, 0); check("br_run", sc_state, 0);
    check("br_count", sc_stall_count, 4);

    // Memory wait with branch arriving during the wait
    do_reset();
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    check("mw_state", sc_state, 3);
    check("mw_ctl", {sc_pc_enable, sc_id_ex_hold, sc_ex_mem_hold, sc_mem_wb_bubble}, 4'b0111);
    cyc(0, 0, 0); check("mw_flush1", sc_state, 2);
    cyc(0, 0, 0); check("mw_flush2", sc_state, 2);
    cyc(0, 0, 0); check("mw_run", sc_state, 0);
    check("mw_count", sc_stall_count, 7);

    // Timeout after 255 memory-wait cycles, sticky until reset
    do_reset();
    for (int i = 0; i < 255; i++) cyc(1, 0, 0);
    check("tmo_not_yet", sc_timeout, 0);
    cyc(1, 0, 0);
    check("tmo_set", sc_timeout, 1);
    for (int i = 0; i < 44; i++) cyc(1, 0, 0);
    cyc(0, 0, 0); cyc(0, 0, 0);
    check("tmo_sticky", sc_timeout, 1);
    check("tmo_run", sc_state, 0);
    do_reset();
    check("tmo_cleared", sc_timeout, 0);

    // All inputs at once, then reset mid-wait discards the pending branch
    do_reset();
    cyc(1, 1, 1); check("sim_memwait", sc_state, 3);
    cyc(0, 0, 0); check("sim_flush", sc_state, 2);
    cyc(0, 0, 0); cyc(0, 0, 0); check("sim_run", sc_state, 0);
    cyc(1, 1, 0); cyc(1, 0, 0);
    mem_sc_busy = 1; ex_sc_branch = 1; reset = 1;
    @(negedge clock);
    reset = 0;
    check("rst_mid_run", sc_state, 0);
    check("rst_mid_count", sc_stall_count, 0);
    cyc(0, 0, 0); check("rst_no_flush", sc_state, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1;
      end else begin
        reset = 0;
      end
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3);
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
